// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential radix-2 shift-add multiplier.
//
// Captures A, B and signed_mode on an accepted start. Runs exactly WIDTH
// add/shift iterations on the operand magnitudes, then applies the result sign
// and presents a registered full-width product together with a one-cycle done
// pulse.
//
// Timing: with start accepted at edge k, product and done update at edge
// k+WIDTH+1, and done is sampled high at edge k+WIDTH+2.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   start        request a new multiply (sampled only in IDLE)
//   signed_mode  0 = unsigned, 1 = two's-complement operands (sampled with start)
//   A, B         WIDTH-bit multiplicand / multiplier (sampled with start)
//   product      2*WIDTH-bit registered result
//   done         one-cycle pulse marking product valid
//   busy         high whenever the FSM is not idle
//
// state  | meaning
// S_IDLE | waiting for start; product holds the last result
// S_RUN  | WIDTH shift-add iterations, then sign fix-up and result load
// S_DONE | done pulse cycle, returns to idle
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);

  logic [1:0]         state_q,   state_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               neg_q,     neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q,    done_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitude as unsigned WIDTH bits: the most-negative value maps onto
  // 2^(WIDTH-1), which still fits, so the unsigned core stays exact.
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (signed_mode && A[WIDTH-1]) a_mag = ~A + ONE_W;
    if (signed_mode && B[WIDTH-1]) b_mag = ~B + ONE_W;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CNT_LOAD;
          neg_d    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mplier_d = mplier_q >> 1;
          mcand_d  = mcand_q << 1;
          cnt_d    = cnt_q - ONE_C;
        end else begin
          // Counter exhausted: apply the sign and publish the result.
          product_d = neg_q ? (~acc_q + ONE_2W) : acc_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_seq_param.sv
module tb_mult_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // index 0 -> WIDTH=8 instance, index 1 -> WIDTH=16 instance
  logic        start_s [2];
  logic        sm_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];

  logic [15:0] prod8;
  logic [31:0] prod16;
  logic        done_w [2];
  logic        busy_w [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_left [2];
  logic [63:0] m_pend [2];
  logic [63:0] m_prod [2];
  logic        m_done [2];

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start_s[0]), .signed_mode(sm_s[0]),
    .A(a_s[0][7:0]), .B(b_s[0][7:0]),
    .product(prod8), .done(done_w[0]), .busy(busy_w[0])
  );

  mult_seq_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start_s[1]), .signed_mode(sm_s[1]),
    .A(a_s[1][15:0]), .B(b_s[1][15:0]),
    .product(prod16), .done(done_w[1]), .busy(busy_w[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] calc(input int w, input logic sm,
                                       input logic [31:0] a, input logic [31:0] b);
    longint ma, sa, sb, p;
    logic [63:0] mask;
    ma = (longint'(1) << w) - 1;
    sa = longint'(a) & ma;
    sb = longint'(b) & ma;
    if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    mask = (64'h1 << (2 * w)) - 64'h1;
    return 64'(p) & mask;
  endfunction

  function automatic logic [63:0] dut_prod(input int i);
    return (i == 0) ? {48'h0, prod8} : {32'h0, prod16};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted multiply occupies WIDTH+2 edges; the result appears
  // one edge before the block goes idle again.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_left[i] = 0;
        m_prod[i] = '0;
        m_done[i] = 1'b0;
      end else if (m_left[i] == 0) begin
        m_done[i] = 1'b0;
        if (start_s[i]) begin
          m_left[i] = wid(i) + 2;
          m_pend[i] = calc(wid(i), sm_s[i], a_s[i], b_s[i]);
        end
      end else begin
        m_left[i] = m_left[i] - 1;
        m_done[i] = (m_left[i] == 1);
        if (m_left[i] == 1) m_prod[i] = m_pend[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("done[%0d]", i), {63'h0, done_w[i]}, {63'h0, m_done[i]});
        chk($sformatf("busy[%0d]", i), {63'h0, busy_w[i]}, {63'h0, (m_left[i] != 0)});
        chk($sformatf("product[%0d]", i), dut_prod(i), m_prod[i]);
      end
    end
  end

  // Pulse start for one cycle, wait for done, check latency and product.
  task automatic run_op(input int i, input logic sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv, input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    start_s[i] = 1'b1; sm_s[i] = sm; a_s[i] = a; b_s[i] = b;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= wid(i) + 8 && !seen; n++) begin
      @(negedge clk);
      start_s[i] = 1'b0;
      if (done_w[i]) begin seen = 1'b1; lat = n; end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(wid(i) + 2));
    chk({nm, "_product"}, dut_prod(i), expv);
  endtask

  initial begin
    int lat;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; sm_s[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
      m_left[i] = 0; m_pend[i] = '0; m_prod[i] = '0; m_done[i] = 1'b0;
    end
    // start asserted together with rst must be ignored
    start_s[0] = 1'b1; a_s[0] = 32'd5; b_s[0] = 32'd5;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_product8", {48'h0, prod8}, 64'h0);
    chk("reset_busy8", {63'h0, busy_w[0]}, 64'h0);
    chk("reset_done16", {63'h0, done_w[1]}, 64'h0);
    start_s[0] = 1'b0;
    rst = 1'b0;

    run_op(0, 1'b0, 32'd21,  32'd18,  64'h017A, "u21x18");
    run_op(0, 1'b0, 32'd255, 32'd255, 64'hFE01, "u255x255");
    run_op(0, 1'b1, 32'hFD,  32'd5,   64'hFFF1, "s_m3x5");
    run_op(0, 1'b1, 32'h80,  32'h80,  64'h4000, "s_m128xm128");
    run_op(0, 1'b1, 32'h00,  32'h80,  64'h0000, "s_0xm128");

    // operands and start changing mid-run must not disturb the result
    @(negedge clk);
    start_s[0] = 1'b1; sm_s[0] = 1'b0; a_s[0] = 32'd12; b_s[0] = 32'd11;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 32'd28; b_s[0] = 32'd56; sm_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 16 && !seen; n++) begin
      @(negedge clk);
      if (done_w[0]) begin seen = 1'b1; lat = n; end
    end
    chk("midrun_seen", {63'h0, seen}, 64'h1);
    chk("midrun_product", {48'h0, prod8}, 64'h0084);
    repeat (6) @(negedge clk);
    chk("midrun_hold", {48'h0, prod8}, 64'h0084);

    // reset in the 4th RUN cycle aborts with no done pulse
    start_s[0] = 1'b1; sm_s[0] = 1'b0; a_s[0] = 32'd100; b_s[0] = 32'd3;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_product", {48'h0, prod8}, 64'h0);
    chk("abort_busy", {63'h0, busy_w[0]}, 64'h0);
    repeat (12) @(negedge clk);
    chk("abort_no_done_product", {48'h0, prod8}, 64'h0);
    run_op(0, 1'b0, 32'd28, 32'd56, 64'h0620, "u28x56");

    run_op(1, 1'b1, 32'h0000FC18, 32'd300, 64'hFFFB6C20, "s16_m1000x300");
    run_op(1, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, "u16_max");

    // start held high: results back-to-back every WIDTH+3 cycles
    @(negedge clk);
    start_s[0] = 1'b1; sm_s[0] = 1'b0; a_s[0] = 32'd7; b_s[0] = 32'd9;
    repeat (24) @(negedge clk);
    start_s[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("held_product", {48'h0, prod8}, 64'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a new multiply; sampled only in IDLE.
REQ-006 Port: signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-007 Port: A  input  WIDTH  multiplicand; sampled with start.
REQ-008 Port: B  input  WIDTH  multiplier; sampled with start.
REQ-009 Port: product  output  2*WIDTH  full-width result, registered.
REQ-010 Port: done  output  1  one-cycle pulse marking product valid.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; busy = (state != IDLE).
REQ-013 In IDLE, start=1 at rising edge k SHALL capture A, B and signed_mode, clear the accumulator, load the iteration counter with WIDTH, and enter RUN.
REQ-014 At capture in signed mode, the block SHALL store operand magnitudes (|A|, |B| as WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1)) and neg = A[MSB] XOR B[MSB]; in unsigned mode, neg = 0 and operands are stored unchanged.
REQ-015 In each RUN cycle, the block SHALL add the shifted multiplicand to the 2*WIDTH accumulator when the current multiplier LSB is 1, shift the multiplier right by one and the multiplicand left by one, and decrement the counter (radix-2 shift-add).
REQ-016 RUN SHALL last exactly WIDTH cycles, edges k+1..k+WIDTH; no early termination on zero operands.
REQ-017 At edge k+WIDTH+1 the block SHALL load product with the accumulator (two's-complement negated if neg=1), set done=1 and enter DONE.
REQ-018 DONE SHALL last one cycle; the next edge SHALL clear done and return to IDLE.
REQ-019 Total latency SHALL be WIDTH+2 edges from start acceptance to done high; throughput is one result per WIDTH+3 cycles with start held high.
REQ-020 start in RUN or DONE SHALL be ignored: no restart, no operand change.
REQ-021 Changes on A, B or signed_mode after capture SHALL NOT affect the in-flight result.
REQ-022 product SHALL hold its value from the done edge until the next done edge; it SHALL NOT change during RUN.
REQ-023 The result SHALL be exact for all operand pairs (no overflow in 2*WIDTH bits), including zero operands and the most-negative-by-most-negative case.
REQ-024 done SHALL never be high for two consecutive cycles.

Reset
REQ-025 rst=1 at any edge SHALL force state=IDLE, product=0, done=0, busy=0 and clear the accumulator, counter and captured operands.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; start asserted in the same cycle as rst SHALL be ignored.
REQ-027 After rst deasserts, the first start SHALL be accepted at the next edge with normal latency.

Verification
REQ-028 WIDTH=8, unsigned, A=21, B=18, one-cycle start -> busy for 10 cycles, single done pulse 10 edges after acceptance, product=16'h017A (378).
REQ-029 WIDTH=8, unsigned, A=255, B=255 -> product=16'hFE01; then signed, A=-3 (8'hFD), B=5 -> product=16'hFFF1 (-15).
REQ-030 WIDTH=8, signed, A=B=8'h80 (-128) -> product=16'h4000; signed A=0, B=8'h80 -> product=16'h0000.
REQ-031 WIDTH=8: accept A=12, B=11; pulse start and change A/B to 28/56 during RUN -> product=16'h0084 (132), one done pulse only; product unchanged until the next accepted start.
REQ-032 WIDTH=8: assert rst at the 4th RUN cycle -> no done pulse, product=0, busy=0 next cycle; then A=28, B=56 -> product=16'h0620 (1568).
REQ-033 WIDTH=16, signed, A=-1000, B=300 -> done at edge k+18, product=32'hFFFB6C20 (-300000).
